// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit CPU core: datapath widths and the
// control-flow opcodes that cause the core to redirect instruction fetch.
package cpu_pkg;

  localparam int INSTR_W  = 19;
  localparam int ADDR_W   = 14;
  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_JMP  = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_BNE  = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_CALL = 5'b01101;
  localparam logic [OPCODE_W-1:0] OP_RET  = 5'b01110;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [ADDR_W-1:0]  iaddr_t;

  // True for opcodes that may drive redirect_valid (BEQ/BNE only when taken).
  function automatic logic is_ctrl_flow(input logic [OPCODE_W-1:0] op);
    return (op == OP_JMP) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_CALL) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {instruction, pc} pairs for the fetch unit;
// the head is combinational and a synchronous flush empties it in one cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = INSTR_W + ADDR_W,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  // Guards keep the pointers consistent even if a caller misbehaves.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage carries no reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory read per cycle under
// a credit rule, and queues responses for the CPU behind a valid/ready handshake.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int INSTR_W    = cpu_pkg::INSTR_W,
  parameter int ADDR_W     = cpu_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_PC   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [ADDR_W-1:0]  req_pc_reg, req_pc_next;
  logic               inflight_reg, inflight_next;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W:0]     credit_used;
  logic               credit_ok, issue, push, pop;

  // Outstanding work = queued entries plus the response still on its way.
  assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(inflight_reg);
  assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);
  // rst gating holds the request low for the whole time reset is asserted.
  assign issue       = rst & fetch_en & ~redirect_valid & credit_ok;

  assign push = inflight_reg & ~redirect_valid;
  assign pop  = instr_valid & instr_ready & ~redirect_valid;

  always_comb begin
    pc_next       = pc_reg;
    req_pc_next   = req_pc_reg;
    inflight_next = issue;
    if (redirect_valid) begin
      pc_next = redirect_addr;
    end else if (issue) begin
      pc_next     = pc_reg + 1'b1;
      req_pc_next = pc_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg       <= ADDR_W'(RESET_PC);
      req_pc_reg   <= '0;
      inflight_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      req_pc_reg   <= req_pc_next;
      inflight_reg <= inflight_next;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_rdata, req_pc_reg}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign imem_req    = issue;
  assign imem_addr   = pc_reg;
  assign instr_valid = (fifo_count != '0);
  // Zero the head when empty so the CPU never sees uninitialised storage.
  assign instruction = instr_valid ? fifo_head[ENTRY_W-1:ADDR_W] : '0;
  assign instr_pc    = instr_valid ? fifo_head[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, redirect,
// PC wrap, fetch_en gating and asynchronous reset mid-stream.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [13:0] redirect_addr = '0;
  logic        instr_ready = 1'b1;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic [18:0] imem_rdata;
  logic        instr_valid;
  logic [18:0] instruction;
  logic [13:0] instr_pc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Synchronous memory model: mem[a] = a + 100, data one cycle after address.
  always @(posedge clk) imem_rdata <= 19'(imem_addr) + 19'd100;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic head_is(input string tag, input int ins, input int pc);
    chk({tag, "_valid"}, 32'(instr_valid), 1);
    chk({tag, "_instr"}, 32'(instruction), 32'(ins));
    chk({tag, "_pc"}, 32'(instr_pc), 32'(pc));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with fetch_en already high.
    tick; tick;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instruction), 0);
    chk("rst_pc", 32'(instr_pc), 0);
    chk("rst_addr", 32'(imem_addr), 0);

    // Stream from power-up.
    rst = 1'b1; #1;
    chk("s_req0", 32'(imem_req), 1);
    chk("s_addr0", 32'(imem_addr), 0);
    tick;
    chk("s_fill_valid", 32'(instr_valid), 0);
    chk("s_addr1", 32'(imem_addr), 1);
    tick;
    for (int k = 0; k < 5; k++) begin
      head_is("stream", 100 + k, k);
      tick;
    end

    // Asynchronous reset with the FIFO non-empty.
    rst = 1'b0; instr_ready = 1'b0; #1;
    chk("ar_valid", 32'(instr_valid), 0);
    chk("ar_req", 32'(imem_req), 0);
    chk("ar_instr", 32'(instruction), 0);
    chk("ar_pc", 32'(instr_pc), 0);
    tick; tick;
    rst = 1'b1; #1;
    chk("ar_restart_req", 32'(imem_req), 1);
    chk("ar_restart_addr", 32'(imem_addr), 0);
    chk("ar_restart_valid", 32'(instr_valid), 0);

    // Backpressure: four issues, then the request drops and the head holds.
    tick;
    chk("bp_no_stale", 32'(instr_valid), 0);
    chk("bp_req1", 32'(imem_req), 1);
    tick;
    head_is("bp_first", 100, 0);
    chk("bp_req2", 32'(imem_req), 1);
    tick;
    chk("bp_req3", 32'(imem_req), 1);
    chk("bp_addr3", 32'(imem_addr), 3);
    tick;
    chk("bp_req_stop", 32'(imem_req), 0);
    for (int i = 0; i < 6; i++) begin
      tick;
      head_is("bp_hold", 100, 0);
      chk("bp_hold_req", 32'(imem_req), 0);
    end
    instr_ready = 1'b1; #1;
    chk("bp_pop_not_credited", 32'(imem_req), 0);
    for (int k = 0; k < 5; k++) begin
      head_is("drain", 100 + k, k);
      tick;
    end

    // Build three queued entries, then redirect to 30.
    instr_ready = 1'b0; #1;
    head_is("pre_redir", 105, 5);
    chk("pre_redir_addr", 32'(imem_addr), 8);
    tick;
    head_is("redir_hold", 105, 5);
    chk("redir_full_req", 32'(imem_req), 0);
    redirect_valid = 1'b1; redirect_addr = 14'd30; #1;
    chk("redir_req_blocked", 32'(imem_req), 0);
    tick;
    redirect_valid = 1'b0; instr_ready = 1'b1; #1;
    chk("redir_flushed", 32'(instr_valid), 0);
    chk("redir_req", 32'(imem_req), 1);
    chk("redir_addr", 32'(imem_addr), 30);
    tick;
    chk("redir_no_stale", 32'(instr_valid), 0);
    chk("redir_addr1", 32'(imem_addr), 31);
    tick;
    head_is("redir_first", 130, 30);
    tick;
    head_is("redir_second", 131, 31);
    tick;
    head_is("redir_third", 132, 32);

    // PC wrap-around through 16383.
    redirect_valid = 1'b1; redirect_addr = 14'd16382; #1;
    chk("wrap_req_blocked", 32'(imem_req), 0);
    tick;
    redirect_valid = 1'b0; #1;
    chk("wrap_flushed", 32'(instr_valid), 0);
    chk("wrap_addr0", 32'(imem_addr), 16382);
    tick;
    chk("wrap_addr1", 32'(imem_addr), 16383);
    tick;
    head_is("wrap_a", 16482, 16382);
    chk("wrap_addr2", 32'(imem_addr), 0);
    tick;
    head_is("wrap_b", 16483, 16383);
    tick;
    head_is("wrap_c", 100, 0);
    tick;
    head_is("wrap_d", 101, 1);

    // fetch_en low with one response in flight.
    fetch_en = 1'b0; #1;
    chk("fe_req_off", 32'(imem_req), 0);
    chk("fe_addr", 32'(imem_addr), 3);
    tick;
    head_is("fe_landed", 102, 2);
    chk("fe_req_still_off", 32'(imem_req), 0);
    tick;
    chk("fe_drained", 32'(instr_valid), 0);
    chk("fe_pc_hold", 32'(imem_addr), 3);
    tick;
    fetch_en = 1'b1; #1;
    chk("fe_resume_req", 32'(imem_req), 1);
    chk("fe_resume_addr", 32'(imem_addr), 3);
    tick;
    chk("fe_resume_fill", 32'(instr_valid), 0);
    tick;
    head_is("fe_resume", 103, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
